// File: rtl/chunk_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, N = WIDTH/CHUNK cycles per op.
// Optional macro CHUNK_ADDSUB_SAT_EN saturates Sum to signed max/min on overflow.
module chunk_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, res;
    logic [KW-1:0]    k;
    logic             c;

    logic [CHUNK-1:0] a_ch, b_ch;
    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] res_nxt, sum_fin;
    logic             last, ovf_nxt;

    always_comb begin
        a_ch    = a_r[k*CHUNK +: CHUNK];
        b_ch    = b_r[k*CHUNK +: CHUNK];
        part    = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c};
        res_nxt = res;
        res_nxt[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        last    = (k == KW'(N - 1));
        // carry into the MSB is recovered from the MSB sum bit; only meaningful on the last chunk
        ovf_nxt = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ part[CHUNK-1] ^ part[CHUNK];
`ifdef CHUNK_ADDSUB_SAT_EN
        if (ovf_nxt)
            sum_fin = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            sum_fin = res_nxt;
`else
        sum_fin = res_nxt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
            k     <= '0;
            c     <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_r   <= A;
                        // subtract folds into add: A + ~B + ~Cin
                        b_r   <= sub ? ~B : B;
                        c     <= sub ? ~Cin : Cin;
                        k     <= '0;
                    end
                end
                RUN: begin
                    res <= res_nxt;
                    c   <= part[CHUNK];
                    k   <= k + 1'b1;
                    if (last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        k     <= '0;
                        Sum   <= sum_fin;
                        Cout  <= part[CHUNK];
                        Ovf   <= ovf_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chunk_addsub.sv
// Scoreboard bench for chunk_addsub (16/4 main instance plus an N=1 instance).
module tb_chunk_addsub;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0, Cin = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic        busy, done, Cout, Ovf;
    logic [15:0] Sum;
    logic        busy1, done1, Cout1, Ovf1;
    logic [15:0] Sum1;

    typedef struct packed {logic [15:0] sum; logic cout; logic ovf;} exp_t;
    exp_t q[$];
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    chunk_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf));

    chunk_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy1), .done(done1), .Sum(Sum1), .Cout(Cout1), .Ovf(Ovf1));

    // Full-width reference: add = A+B+Cin, sub = A+~B+~Cin
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci);
        logic [15:0] bb;
        logic [16:0] t;
        exp_t e;
        bb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {16'h0, (s ? ~ci : ci)};
        e.sum  = t[15:0];
        e.cout = t[16];
        e.ovf  = (a[15] == bb[15]) && (t[15] != a[15]);
`ifdef CHUNK_ADDSUB_SAT_EN
        if (e.ovf) e.sum = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return e;
    endfunction

    // Caller is at a negedge; start is seen by the next rising edge.
    task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci, input exp_t e);
        A = a; B = b; sub = s; Cin = ci; start = 1'b1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat = rising edges after the accept edge when done is first seen
    task automatic wait_done(output int lat, output int bcnt, output bit ok);
        lat = 0; bcnt = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin ok = 1'b1; break; end
            if (busy) bcnt++;
            lat++;
            @(negedge clk);
        end
    endtask

    logic [15:0] va [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0009};
    logic [15:0] vb [6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0004};
    logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef CHUNK_ADDSUB_SAT_EN
    logic [15:0] vsum [6] = '{16'h2233, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFE, 16'h0004};
`else
    logic [15:0] vsum [6] = '{16'h2233, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h0004};
`endif
    logic        vco [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        vov [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++; if ({busy, done, Cout, Ovf} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b exp 0000", {busy, done, Cout, Ovf}); end
        n_checks++; if (Sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum: got %h exp 0000", Sum); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int lat, bcnt; bit ok; exp_t e;
        for (int i = 0; i < 6; i++) begin
            drive_op(va[i], vb[i], vs[i], vc[i], '{vsum[i], vco[i], vov[i]});
            wait_done(lat, bcnt, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL dir%0d timeout: no done within 20 cycles", i); end
            e = q.pop_front();
            n_checks++; if (Sum !== e.sum) begin n_fail++; $display("FAIL dir%0d sum: got %h exp %h", i, Sum, e.sum); end
            n_checks++; if ({Cout, Ovf} !== {e.cout, e.ovf}) begin n_fail++; $display("FAIL dir%0d cout_ovf: got %b exp %b", i, {Cout, Ovf}, {e.cout, e.ovf}); end
            n_checks++; if (lat != 4 || bcnt != 4) begin n_fail++; $display("FAIL dir%0d latency: got lat %0d busy %0d exp 4 4", i, lat, bcnt); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d busy_at_done: got %b exp 0", i, busy); end
            @(negedge clk);
            n_checks++; if (done !== 1'b0 || Sum !== e.sum) begin n_fail++; $display("FAIL dir%0d pulse_hold: done %b sum %h exp 0 %h", i, done, Sum, e.sum); end
        end
    endtask

    task automatic test_random();
        int lat, bcnt; bit ok; exp_t e;
        logic [15:0] a, b; logic s, ci;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom); ci = 1'($urandom);
            drive_op(a, b, s, ci, model(a, b, s, ci));
            wait_done(lat, bcnt, ok);
            e = q.pop_front();
            n_checks++; if (!ok || {Sum, Cout, Ovf} !== {e.sum, e.cout, e.ovf}) begin n_fail++;
                $display("FAIL rnd%0d %h %h s%b c%b: got %h %b %b exp %h %b %b", i, a, b, s, ci, Sum, Cout, Ovf, e.sum, e.cout, e.ovf); end
            @(negedge clk);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bcnt; bit ok, extra; exp_t e;
        drive_op(16'h0100, 16'h0023, 1'b0, 1'b0, '{16'h0123, 1'b0, 1'b0});
        A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1; Cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt, ok);
        e = q.pop_front();
        n_checks++; if (!ok || Sum !== e.sum || Cout !== e.cout) begin n_fail++; $display("FAIL busy_ignore result: got %h %b exp %h %b", Sum, Cout, e.sum, e.cout); end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL busy_ignore latency: got %0d exp 3", lat); end
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (done || busy) extra = 1'b1; end
        n_checks++; if (extra) begin n_fail++; $display("FAIL busy_ignore restart: got extra op exp none"); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt; bit ok, pulsed; exp_t e;
        drive_op(16'h1111, 16'h2222, 1'b0, 1'b0, '{16'h3333, 1'b0, 1'b0});
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || Sum !== 16'h0) begin n_fail++; $display("FAIL rst_mid async: busy %b sum %h exp 0 0000", busy, Sum); end
        q.delete();
        pulsed = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (done) pulsed = 1'b1; end
        n_checks++; if (pulsed) begin n_fail++; $display("FAIL rst_mid done: got pulse exp none"); end
        rst = 1'b0;
        drive_op(16'h0042, 16'h0001, 1'b1, 1'b0, '{16'h0041, 1'b1, 1'b0});
        wait_done(lat, bcnt, ok);
        e = q.pop_front();
        n_checks++; if (!ok || lat != 4 || Sum !== e.sum || Cout !== e.cout) begin n_fail++;
            $display("FAIL rst_mid resume: got %h %b lat %0d exp %h %b lat 4", Sum, Cout, lat, e.sum, e.cout); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bcnt; bit ok, held; exp_t e1, e2;
        drive_op(16'h00F0, 16'h000F, 1'b0, 1'b1, '{16'h0100, 1'b0, 1'b0});
        wait_done(lat, bcnt, ok);
        e1 = q.pop_front();
        n_checks++; if (!ok || Sum !== e1.sum) begin n_fail++; $display("FAIL b2b first: got %h exp %h", Sum, e1.sum); end
        drive_op(16'h4000, 16'h4000, 1'b0, 1'b0, model(16'h4000, 16'h4000, 1'b0, 1'b0));
        n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b accept: done %b busy %b exp 0 1", done, busy); end
        lat = 0; held = 1'b1;
        while (!done && lat < 20) begin
            if (Sum !== e1.sum) held = 1'b0;
            lat++;
            @(negedge clk);
        end
        e2 = q.pop_front();
        n_checks++; if (!held) begin n_fail++; $display("FAIL b2b hold: first result not held exp %h", e1.sum); end
        n_checks++; if (lat != 4 || {Sum, Cout, Ovf} !== {e2.sum, e2.cout, e2.ovf}) begin n_fail++;
            $display("FAIL b2b second: got %h %b %b lat %0d exp %h %b %b lat 4", Sum, Cout, Ovf, lat, e2.sum, e2.cout, e2.ovf); end
        @(negedge clk);
    endtask

    task automatic test_n1();
        int lat, bcnt; bit ok; exp_t e, e1;
        e1 = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drive_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, e1);
        n_checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin n_fail++; $display("FAIL n1 run: busy %b done %b exp 1 0", busy1, done1); end
        @(negedge clk);
        n_checks++; if (done1 !== 1'b1 || {Sum1, Cout1, Ovf1} !== {e1.sum, e1.cout, e1.ovf}) begin n_fail++;
            $display("FAIL n1 result: done %b got %h %b %b exp %h %b %b", done1, Sum1, Cout1, Ovf1, e1.sum, e1.cout, e1.ovf); end
        wait_done(lat, bcnt, ok);
        e = q.pop_front();
        n_checks++; if (!ok || Sum !== e.sum || Ovf !== e.ovf) begin n_fail++; $display("FAIL n1 main: got %h %b exp %h %b", Sum, Ovf, e.sum, e.ovf); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_n1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
